// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_gen
// Description : Streaming 3x3 neighbourhood generator for the Sobel kernel.
//               Takes a raster-order pixel stream (one pixel per cycle),
//               keeps the two previous image rows in line buffers and emits
//               every fully populated interior 3x3 window together with the
//               coordinates of its centre on a valid/ready output.
// Ports       : clk_i        - clock, rising edge
//               rst_i        - asynchronous reset, active low
//               pix_i        - input pixel
//               pix_sof_i    - pixel is (0,0) of a new frame
//               pix_valid_i  - input pixel valid
//               pix_ready_o  - input ready (= !win_valid_o || win_ready_i)
//               win_o        - window, element (r,c) at PIX_W*(3r+c);
//                              r=0 oldest row, c=0 oldest column
//               win_x_o      - x of window centre
//               win_y_o      - y of window centre
//               win_eof_o    - last window of the frame
//               win_valid_o  - window valid
//               win_ready_i  - downstream ready
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_gen #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PIX_W-1:0]   pix_i,
  input  logic               pix_sof_i,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  output logic [9*PIX_W-1:0] win_o,
  output logic [XW-1:0]      win_x_o,
  output logic [YW-1:0]      win_y_o,
  output logic               win_eof_o,
  output logic               win_valid_o,
  input  logic               win_ready_i
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  // Position of the next pixel to be accepted
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Line buffers: lb1 holds row y-1, lb2 holds row y-2 (not reset)
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] lb2_q [IMG_W];

  // Window shift register and output qualifiers
  logic [9*PIX_W-1:0] win_q, win_d;
  logic [XW-1:0]      win_x_q, win_x_d;
  logic [YW-1:0]      win_y_q, win_y_d;
  logic               win_eof_q, win_eof_d;
  logic               win_valid_q, win_valid_d;

  logic               w_accept;
  logic               w_take;
  logic               w_emit;
  logic [XW-1:0]      w_pos_x;
  logic [YW-1:0]      w_pos_y;
  logic [PIX_W-1:0]   w_lb1_rd;
  logic [PIX_W-1:0]   w_lb2_rd;

  assign pix_ready_o = !win_valid_q || win_ready_i;
  assign w_accept    = pix_valid_i && pix_ready_o;
  assign w_take      = win_valid_q && win_ready_i;

  // A start-of-frame pixel is always (0,0), whatever the counters say
  assign w_pos_x = pix_sof_i ? '0 : x_q;
  assign w_pos_y = pix_sof_i ? '0 : y_q;

  // Reads see the contents before this cycle's write
  assign w_lb1_rd = lb1_q[w_pos_x];
  assign w_lb2_rd = lb2_q[w_pos_x];

  // Only interior positions complete a window; rows 0/1 and the first two
  // columns of each row never emit, which also keeps stale line-buffer data
  // and the previous line's columns out of the output.
  assign w_emit = w_accept && (w_pos_x >= X_TWO) && (w_pos_y >= Y_TWO);

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    win_d       = win_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    win_eof_d   = win_eof_q;
    win_valid_d = win_valid_q;

    if (w_accept) begin
      if (w_pos_x == X_LAST) begin
        x_d = '0;
        y_d = (w_pos_y == Y_LAST) ? '0 : w_pos_y + 1'b1;
      end else begin
        x_d = w_pos_x + 1'b1;
        y_d = w_pos_y;
      end

      // Shift columns toward c=0 and load the new column at c=2
      for (int r = 0; r < 3; r++) begin
        win_d[PIX_W*(3*r)   +: PIX_W] = win_q[PIX_W*(3*r+1) +: PIX_W];
        win_d[PIX_W*(3*r+1) +: PIX_W] = win_q[PIX_W*(3*r+2) +: PIX_W];
      end
      win_d[PIX_W*2 +: PIX_W] = w_lb2_rd;
      win_d[PIX_W*5 +: PIX_W] = w_lb1_rd;
      win_d[PIX_W*8 +: PIX_W] = pix_i;
    end

    if (w_emit) begin
      win_valid_d = 1'b1;
      win_x_d     = w_pos_x - 1'b1;
      win_y_d     = w_pos_y - 1'b1;
      win_eof_d   = (w_pos_x == X_LAST) && (w_pos_y == Y_LAST);
    end else if (w_take) begin
      win_valid_d = 1'b0;
      win_eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q         <= '0;
      y_q         <= '0;
      win_q       <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      win_eof_q   <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      win_q       <= win_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      win_eof_q   <= win_eof_d;
      win_valid_q <= win_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      lb2_q[w_pos_x] <= w_lb1_rd;
      lb1_q[w_pos_x] <= pix_i;
    end
  end

  assign win_o       = win_q;
  assign win_x_o     = win_x_q;
  assign win_y_o     = win_y_q;
  assign win_eof_o   = win_eof_q;
  assign win_valid_o = win_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_window_gen
// Description : Self-checking bench for sobel_window_gen. DUT a is 4x3,
//               DUT b is 5x4. A frame-memory reference model fills a
//               scoreboard queue on every accepted pixel; windows are popped
//               and compared when taken downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_gen;

  typedef struct {
    logic [71:0] w;
    int          x;
    int          y;
    bit          eof;
  } exp_t;

  typedef struct {
    int          pix;
    bit          sof;
    bit          ev;
    logic [71:0] ew;
    int          ex;
    int          ey;
    bit          eeof;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT a: 4x3
  logic [7:0]  a_pix;
  logic        a_sof, a_valid, a_pready, a_eof, a_wvalid, a_wready;
  logic [71:0] a_win;
  logic [1:0]  a_wx;
  logic [1:0]  a_wy;
  // DUT b: 5x4
  logic [7:0]  b_pix;
  logic        b_sof, b_valid, b_pready, b_eof, b_wvalid, b_wready;
  logic [71:0] b_win;
  logic [2:0]  b_wx;
  logic [1:0]  b_wy;

  sobel_window_gen #(.PIX_W(8), .IMG_W(4), .IMG_H(3)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .pix_i(a_pix), .pix_sof_i(a_sof),
    .pix_valid_i(a_valid), .pix_ready_o(a_pready), .win_o(a_win),
    .win_x_o(a_wx), .win_y_o(a_wy), .win_eof_o(a_eof),
    .win_valid_o(a_wvalid), .win_ready_i(a_wready)
  );

  sobel_window_gen #(.PIX_W(8), .IMG_W(5), .IMG_H(4)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .pix_i(b_pix), .pix_sof_i(b_sof),
    .pix_valid_i(b_valid), .pix_ready_o(b_pready), .win_o(b_win),
    .win_x_o(b_wx), .win_y_o(b_wy), .win_eof_o(b_eof),
    .win_valid_o(b_wvalid), .win_ready_i(b_wready)
  );

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   mx[2];
  int   my[2];
  int   img[2][4][5];
  int   cnt[2];
  int   eof_cnt[2];
  logic [71:0] first_win[2];
  bit   stall_q[2];
  logic [71:0] pw[2];
  logic [23:0] pm[2];
  bit   b_rand = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Reference: store the frame as a 2-D image, cut windows out of it
  task automatic model_accept(input int d, input int pix, input bit sof);
    int   x, y, w, h;
    exp_t e;
    w = (d == 0) ? 4 : 5;
    h = (d == 0) ? 3 : 4;
    x = sof ? 0 : mx[d];
    y = sof ? 0 : my[d];
    img[d][y][x] = pix;
    if (x >= 2 && y >= 2) begin
      e.w = pack9(img[d][y-2][x-2], img[d][y-2][x-1], img[d][y-2][x],
                  img[d][y-1][x-2], img[d][y-1][x-1], img[d][y-1][x],
                  img[d][y][x-2],   img[d][y][x-1],   img[d][y][x]);
      e.x   = x - 1;
      e.y   = y - 1;
      e.eof = (x == w - 1) && (y == h - 1);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    x++;
    if (x == w) begin
      x = 0;
      y++;
      if (y == h) y = 0;
    end
    mx[d] = x;
    my[d] = y;
  endtask

  task automatic mon(input int d);
    logic [71:0] w;
    logic [23:0] meta;
    int   x, y;
    bit   eof, vld, wr, pr, pv, ps, have;
    logic [7:0] px;
    exp_t e;
    w   = (d == 0) ? a_win    : b_win;
    x   = (d == 0) ? int'(a_wx) : int'(b_wx);
    y   = (d == 0) ? int'(a_wy) : int'(b_wy);
    eof = (d == 0) ? a_eof    : b_eof;
    vld = (d == 0) ? a_wvalid : b_wvalid;
    wr  = (d == 0) ? a_wready : b_wready;
    pr  = (d == 0) ? a_pready : b_pready;
    pv  = (d == 0) ? a_valid  : b_valid;
    ps  = (d == 0) ? a_sof    : b_sof;
    px  = (d == 0) ? a_pix    : b_pix;
    meta = {7'd0, vld, 7'd0, eof, 4'(x), 4'(y)};

    chk($sformatf("ready_rule%0d", d), 72'(pr), 72'(!vld || wr));
    if (stall_q[d]) begin
      chk($sformatf("stall_win%0d", d), w, pw[d]);
      chk($sformatf("stall_meta%0d", d), 72'(meta), 72'(pm[d]));
    end
    stall_q[d] = vld && !wr;
    pw[d] = w;
    pm[d] = meta;

    if (vld && wr) begin
      have = 1'b0;
      if (d == 0 && q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
      if (d == 1 && q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL unexpected_win%0d: got window at (%0d,%0d) expected none", d, x, y);
      end else begin
        chk($sformatf("win_data%0d", d), w, e.w);
        chk($sformatf("win_meta%0d", d), {8'(x), 8'(y), 7'd0, eof},
            {8'(e.x), 8'(e.y), 7'd0, e.eof});
      end
      if (cnt[d] == 0) first_win[d] = w;
      cnt[d]++;
      if (eof) eof_cnt[d]++;
    end

    if (pv && pr) model_accept(d, int'(px), ps);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  // Random downstream back-pressure for DUT b
  initial begin
    b_wready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      b_wready = b_rand ? ($urandom_range(0, 9) < 6) : 1'b1;
    end
  end

  // Entered and left at posedge+2
  task automatic send(input int d, input int pix, input bit sof, input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 9) < 3) begin
        b_valid = 1'b0;
        @(posedge clk);
        #2;
      end
    end
    if (d == 0) begin a_pix = 8'(pix); a_sof = sof; a_valid = 1'b1; end
    else        begin b_pix = 8'(pix); b_sof = sof; b_valid = 1'b1; end
    n = 0;
    forever begin
      @(negedge clk);
      if ((d == 0) ? a_pready : b_pready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout%0d: got no accept expected accept", d);
        break;
      end
    end
    @(posedge clk);
    #2;
    if (d == 0) begin a_valid = 1'b0; a_sof = 1'b0; end
    else        begin b_valid = 1'b0; b_sof = 1'b0; end
  endtask

  task automatic settle_a(input int ncyc, input int exp_cnt, input string name);
    repeat (ncyc) @(posedge clk);
    #2;
    chk({name, "_count"}, 72'(cnt[0]), 72'(exp_cnt));
    chk({name, "_drained"}, 72'(q0.size()), 72'd0);
  endtask

  vec_t tbl[12];
  logic [71:0] w1, w2;

  initial begin
    int n;
    w1 = pack9(0, 1, 2, 4, 5, 6, 8, 9, 10);
    w2 = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    for (int i = 0; i < 12; i++) tbl[i] = '{i, (i == 0), 1'b0, 72'd0, 0, 0, 1'b0};
    tbl[10] = '{10, 1'b0, 1'b1, w1, 1, 1, 1'b0};
    tbl[11] = '{11, 1'b0, 1'b1, w2, 2, 1, 1'b1};

    rst_n = 1'b0;
    a_pix = '0; a_sof = 1'b0; a_valid = 1'b0; a_wready = 1'b1;
    b_pix = '0; b_sof = 1'b0; b_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0; my[d] = 0; cnt[d] = 0; eof_cnt[d] = 0; stall_q[d] = 1'b0;
    end

    // Reset state
    #12;
    chk("rst_valid", 72'(a_wvalid), 72'd0);
    chk("rst_eof", 72'(a_eof), 72'd0);
    chk("rst_win", a_win, 72'd0);
    chk("rst_xy", 72'({a_wx, a_wy}), 72'd0);
    chk("rst_ready", 72'(a_pready), 72'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 1: table-driven 4x3 frame, continuous valid, no back-pressure
    for (int i = 0; i < 12; i++) begin
      a_pix = 8'(tbl[i].pix); a_sof = tbl[i].sof; a_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("t1_valid[%0d]", i), 72'(a_wvalid), 72'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("t1_win", a_win, tbl[i].ew);
        chk("t1_x", 72'(a_wx), 72'(tbl[i].ex));
        chk("t1_y", 72'(a_wy), 72'(tbl[i].ey));
        chk("t1_eof", 72'(a_eof), 72'(tbl[i].eeof));
      end
      #1;
    end
    a_valid = 1'b0; a_sof = 1'b0;
    settle_a(3, 2, "t1");

    // 2: stall 5 cycles on the first window
    cnt[0] = 0;
    for (int k = 0; k < 11; k++) begin
      a_pix = 8'(k); a_sof = (k == 0); a_valid = 1'b1;
      @(posedge clk);
      #2;
    end
    a_wready = 1'b0; a_pix = 8'd11; a_sof = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("t2_stall_ready", 72'(a_pready), 72'd0);
      chk("t2_stall_valid", 72'(a_wvalid), 72'd1);
      chk("t2_stall_win", a_win, w1);
      #1;
    end
    a_wready = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_w2_valid", 72'(a_wvalid), 72'd1);
    chk("t2_w2_win", a_win, w2);
    chk("t2_w2_meta", 72'({a_wx, a_wy, a_eof}), 72'({2'd2, 2'd1, 1'b1}));
    #1;
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t2_idle_valid", 72'(a_wvalid), 72'd0);
    #1;
    settle_a(2, 2, "t2");

    // 3: back-to-back frames A (4y+x) and B (+100)
    cnt[0] = 0;
    for (int k = 0; k < 24; k++)
      send(0, (k < 12) ? k : 100 + k - 12, (k % 12) == 0, 1'b0);
    settle_a(3, 4, "t3");

    // 4: sof at frame position (2,1)
    for (int k = 0; k < 6; k++) send(0, k, k == 0, 1'b0);
    cnt[0] = 0;
    for (int k = 0; k < 12; k++) send(0, 50 + k, k == 0, 1'b0);
    settle_a(3, 2, "t4");
    chk("t4_first", first_win[0], pack9(50, 51, 52, 54, 55, 56, 58, 59, 60));

    // 5: 1-cycle reset while a window is on the output
    for (int k = 0; k < 11; k++) send(0, k, k == 0, 1'b0);
    chk("t5_pre_valid", 72'(a_wvalid), 72'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 72'(a_wvalid), 72'd0);
    chk("t5_rst_ready", 72'(a_pready), 72'd1);
    chk("t5_rst_win", a_win, 72'd0);
    q0.delete();
    mx[0] = 0; my[0] = 0; stall_q[0] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cnt[0] = 0;
    // No sof: the counters themselves must be back at (0,0)
    for (int k = 0; k < 12; k++) send(0, 200 + k, 1'b0, 1'b0);
    settle_a(3, 2, "t5");
    chk("t5_first", first_win[0], pack9(200, 201, 202, 204, 205, 206, 208, 209, 210));

    // 6: 5x4 frames with random valid gaps and random back-pressure
    b_rand = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 20; k++)
        send(1, 30 * f + 7 * k + 3, k == 0, 1'b1);
    b_valid = 1'b0;
    n = 0;
    while (q1.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    b_rand = 1'b0;
    #2;
    chk("t6_drained", 72'(q1.size()), 72'd0);
    chk("t6_count", 72'(cnt[1]), 72'd12);
    chk("t6_eof_count", 72'(eof_cnt[1]), 72'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 neighbourhood generator that feeds the Sobel kernel. Accepts a raster-order pixel stream one pixel per cycle. Holds the two previous image rows in line buffers and presents a complete 3x3 window plus its centre coordinates on a valid/ready output. Sits between the camera/frame ingest path and `kernel` in the stereo-vision pipeline. Only interior windows are emitted, so every window it produces is fully populated and no border handling is needed.

## Interface

Parameters:
- PIX_W, 8, pixel width in bits
- IMG_W, 640, image width in pixels (>= 3)
- IMG_H, 480, image height in lines (>= 3)
- XW, $clog2(IMG_W), width of the x coordinate
- YW, $clog2(IMG_H), width of the y coordinate

Ports:
- clk_i, in, 1, single clock; all logic is on its rising edge
- rst_i, in, 1, asynchronous, active-low reset
- pix_i, in, PIX_W, input pixel
- pix_sof_i, in, 1, qualifies pix_i as pixel (0,0) of a new frame
- pix_valid_i, in, 1, input pixel valid
- pix_ready_o, out, 1, input ready
- win_o, out, 9*PIX_W, window; element (r,c) at [PIX_W*(3*r+c) +: PIX_W]; r=0 is the oldest row, c=0 is the oldest column
- win_x_o, out, XW, x of the window centre
- win_y_o, out, YW, y of the window centre
- win_eof_o, out, 1, last window of the frame
- win_valid_o, out, 1, window valid
- win_ready_i, in, 1, downstream ready

## Operation

- A pixel is accepted when pix_valid_i && pix_ready_o.
- pix_ready_o = !win_valid_o || win_ready_i (combinational). This is a single output register stage with no skid buffer.
- Counters x (0..IMG_W-1) and y (0..IMG_H-1) give the position of the next accepted pixel:
  - An accept with pix_sof_i=1 is treated as position (0,0), regardless of the counter values.
  - After each accept, x increments. At IMG_W-1, x wraps to 0 and y increments. At (IMG_W-1, IMG_H-1), both wrap to 0.
- Line buffers LB1 (row y-1) and LB2 (row y-2) are IMG_W entries each, addressed by x:
  - On accept, the design reads LB1[x] and LB2[x], then writes LB2[x] <= LB1[x] and LB1[x] <= pix_i.
  - Reads return the pre-write contents.
  - Line buffer contents are not reset.
- The window is a 3x3 shift register. On accept, columns shift toward c=0, and the new column c=2 is loaded as {r0=LB2[x], r1=LB1[x], r2=pix_i}.
- An accept at position (x,y) with x>=2 and y>=2 produces a window with centre (x-1, y-1). Other positions produce no window.
- win_eof_o=1 when the centre is (IMG_W-2, IMG_H-2).
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- The window shift register updates on every accept, including positions that emit nothing. Columns from the previous line are never emitted because x>=2 is required.
- A mid-frame pix_sof_i restarts counting at (0,0). Stale line-buffer data is never emitted, because rows 0 and 1 produce no windows.

## Timing

- Reset values: win_valid_o=0, win_eof_o=0, win_o=0, win_x_o=0, win_y_o=0, x=y=0. pix_ready_o=1 while in reset.
- Latency: the window for a pixel accepted in cycle N is presented in cycle N+1.
- Throughput: one pixel and up to one window per cycle when win_ready_i=1.
- Output handshake:
  - win_valid_o, set in cycle N+1, is cleared when the window is taken (win_valid_o && win_ready_i) and no new window is produced in the same cycle.
  - A simultaneous take and a new window-producing accept keeps win_valid_o=1 with the new data.
- Stall: while win_valid_o && !win_ready_i, the outputs must hold stable and pix_ready_o=0. No pixel is lost or duplicated.
- pix_valid_i gaps: no window is produced, and the counters and window hold.
- Reset assertion mid-frame:
  - Outputs return to reset values immediately, since reset is asynchronous.
  - The counters return to (0,0).
  - The next frame must begin with pix_sof_i, or is assumed to begin at (0,0).

## Test plan

- IMG_W=4, IMG_H=3, pixel value = 4y+x, win_ready_i=1, continuous valid:
  - Exactly 2 windows.
  - Centre (1,1): {0,1,2,4,5,6,8,9,10}, eof=0.
  - Centre (2,1): {1,2,3,5,6,7,9,10,11}, eof=1.
  - Each window appears one cycle after pixels 10 and 11 are accepted, respectively.
- Same image, with win_ready_i held low for 5 cycles when the first window appears:
  - pix_ready_o=0 and win_o stays stable throughout the stall.
  - After release, the second window follows, with identical values to the unstalled run.
- IMG_W=5, IMG_H=4, random pix_valid_i gaps and random win_ready_i:
  - The window stream matches a reference model: 6 windows, centres in raster order (1,1)..(3,2).
  - Only the last window has eof=1.
- Back-to-back frames: frame B (values +100) follows frame A with no gap, IMG_W=4, IMG_H=3:
  - Frame B windows contain only frame-B values, e.g. first window {100,101,102,104,...}.
- pix_sof_i asserted at frame position (2,1):
  - Counting restarts and no window is produced until new position (2,2).
  - The first window has centre (1,1) and contains only post-sof pixels.
- rst_i asserted low for 1 cycle mid-frame while win_valid_o=1:
  - win_valid_o=0 asynchronously and pix_ready_o=1.
  - The following clean frame produces correct windows.
